// File: rtl/multicycle_control.sv
// Multicycle RISC-V subset control FSM: lw, sw, R-type, addi, beq.
// Define MULTICYCLE_CONTROL_MEM_WAIT_EN to add the mem_ready handshake on memory states.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_control,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  state_t state_q, state_d;
  logic   mem_go;

`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = FETCH;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    adr_src       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    result_src    = RES_ALUOUT;
    alu_control   = ALU_ADD;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    state         = state_q;

    case (state_q)
      FETCH: begin
        adr_src    = 1'b0;
        mem_read   = 1'b1;
        ir_write   = mem_go;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        pc_write   = mem_go;
        state_d    = mem_go ? DECODE : FETCH;
      end
      DECODE: begin
        // ALUOut captures the branch target for a possible BEQ
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          default: begin
            state_d       = FETCH;
            illegal_instr = 1'b1;
            instr_done    = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src    = 1'b1;
        mem_read   = 1'b1;
        result_src = RES_ALUOUT;
        state_d    = mem_go ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        result_src = RES_ALUOUT;
        instr_done = mem_go;
        state_d    = mem_go ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        case ({funct7_5, funct3})
          4'b1000: alu_control = ALU_SUB;
          4'b0111: alu_control = ALU_AND;
          4'b0110: alu_control = ALU_OR;
          default: alu_control = ALU_ADD;
        endcase
        state_d = ALUWB;
      end
      EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = ALUWB;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BEQ: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = ALU_SUB;
        result_src  = RES_ALUOUT;
        pc_write    = zero;
        instr_done  = 1'b1;
        state_d     = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Reset forces every output low regardless of the current state
    if (reset) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      adr_src       = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = '0;
      alu_src_b     = '0;
      result_src    = '0;
      alu_control   = '0;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
      state         = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: per-instruction state traces and strobes.
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ready = 1'b1;
  logic [6:0] opcode = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_control;
  logic       instr_done, illegal_instr;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  // {pc,ir,adr,mr,mw,rw,srca,srcb,res,alu,done,ill,state}
  localparam logic [19:0] FETCH_OUTS = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10,
                                        2'b10, 2'b00, 1'b0, 1'b0, 4'd0};
  logic [19:0] outs;
  assign outs = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, alu_src_a,
                 alu_src_b, result_src, alu_control, instr_done, illegal_instr, state};

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk),
    .reset(reset),
`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .opcode(opcode),
    .funct3(funct3),
    .funct7_5(funct7_5),
    .zero(zero),
    .pc_write(pc_write),
    .ir_write(ir_write),
    .adr_src(adr_src),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .reg_write(reg_write),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .result_src(result_src),
    .alu_control(alu_control),
    .instr_done(instr_done),
    .illegal_instr(illegal_instr),
    .state(state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Records one instruction, starting in FETCH, until instr_done (bounded to 8 cycles).
  task automatic capture(output logic [31:0] st, output logic [7:0] rw, output logic [7:0] mw,
                         output logic [7:0] mr, output logic [7:0] pw, output logic [7:0] ill,
                         output logic [15:0] ac, output int len, output logic clash);
    st = '1; rw = '0; mw = '0; mr = '0; pw = '0; ill = '0; ac = '0; len = 0; clash = 1'b0;
    for (int i = 0; i < 8; i++) begin
      st[i*4 +: 4] = state;
      rw[i] = reg_write;
      mw[i] = mem_write;
      mr[i] = mem_read;
      pw[i] = pc_write;
      ill[i] = illegal_instr;
      ac[i*2 +: 2] = alu_control;
      if ((mem_read && mem_write) || (reg_write && mem_write)) clash = 1'b1;
      if (instr_done) begin
        len = i + 1;
        step();
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if (outs !== 20'h0) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=%h", outs, 20'h0);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== FETCH_OUTS) begin
      failures++;
      $display("FAIL reset_release_fetch got=%h exp=%h", outs, FETCH_OUTS);
    end
  endtask

  task automatic test_lw();
    logic [31:0] st; logic [7:0] rw, mw, mr, pw, ill; logic [15:0] ac; int len; logic clash;
    opcode = 7'b0000011;
    capture(st, rw, mw, mr, pw, ill, ac, len, clash);
    checks++;
    if (st !== 32'hFFF43210 || len !== 5) begin
      failures++;
      $display("FAIL lw_seq got=%h len=%0d exp=FFF43210 len=5", st, len);
    end
    checks++;
    if (rw !== 8'b00010000 || mr !== 8'b00001001 || clash !== 1'b0) begin
      failures++;
      $display("FAIL lw_strobes rw=%b mr=%b clash=%b exp rw=00010000 mr=00001001 clash=0",
               rw, mr, clash);
    end
  endtask

  task automatic test_sw();
    logic [31:0] st; logic [7:0] rw, mw, mr, pw, ill; logic [15:0] ac; int len; logic clash;
    opcode = 7'b0100011;
    capture(st, rw, mw, mr, pw, ill, ac, len, clash);
    checks++;
    if (st !== 32'hFFFF5210 || len !== 4) begin
      failures++;
      $display("FAIL sw_seq got=%h len=%0d exp=FFFF5210 len=4", st, len);
    end
    checks++;
    if (mw !== 8'b00001000 || rw !== 8'h00 || clash !== 1'b0) begin
      failures++;
      $display("FAIL sw_strobes mw=%b rw=%b clash=%b exp mw=00001000 rw=00000000 clash=0",
               mw, rw, clash);
    end
  endtask

  task automatic test_rtype();
    logic [31:0] st; logic [7:0] rw, mw, mr, pw, ill; logic [15:0] ac; int len; logic clash;
    logic [3:0] fsel [3] = '{4'b1000, 4'b0110, 4'b0111};
    logic [1:0] aexp [3] = '{2'b01, 2'b11, 2'b10};
    opcode = 7'b0110011;
    for (int k = 0; k < 3; k++) begin
      {funct7_5, funct3} = fsel[k];
      capture(st, rw, mw, mr, pw, ill, ac, len, clash);
      checks++;
      if (st !== 32'hFFFF8610 || len !== 4 || rw !== 8'b00001000) begin
        failures++;
        $display("FAIL rtype_seq%0d got=%h len=%0d rw=%b exp=FFFF8610 len=4 rw=00001000",
                 k, st, len, rw);
      end
      checks++;
      if (ac[5:4] !== aexp[k] || ac[3:0] !== 4'b0000) begin
        failures++;
        $display("FAIL rtype_alu%0d got=%b fetch/decode=%b exp=%b/0000", k, ac[5:4], ac[3:0],
                 aexp[k]);
      end
    end
    {funct7_5, funct3} = 4'b0000;
  endtask

  task automatic test_addi();
    logic [31:0] st; logic [7:0] rw, mw, mr, pw, ill; logic [15:0] ac; int len; logic clash;
    opcode = 7'b0010011;
    funct3 = 3'b111;
    capture(st, rw, mw, mr, pw, ill, ac, len, clash);
    funct3 = 3'b000;
    checks++;
    if (st !== 32'hFFFF8710 || len !== 4 || rw !== 8'b00001000 || ac !== 16'h0) begin
      failures++;
      $display("FAIL addi_seq got=%h len=%0d rw=%b ac=%h exp=FFFF8710 len=4 rw=00001000 ac=0000",
               st, len, rw, ac);
    end
  endtask

  task automatic test_beq();
    logic [31:0] st; logic [7:0] rw, mw, mr, pw, ill; logic [15:0] ac; int len; logic clash;
    opcode = 7'b1100011;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      capture(st, rw, mw, mr, pw, ill, ac, len, clash);
      checks++;
      if (st !== 32'hFFFFF910 || len !== 3) begin
        failures++;
        $display("FAIL beq_seq_z%0d got=%h len=%0d exp=FFFFF910 len=3", z, st, len);
      end
      checks++;
      if (pw[2:0] !== {z[0], 2'b01} || ac[5:4] !== 2'b01) begin
        failures++;
        $display("FAIL beq_pcw_z%0d pw=%b alu=%b exp pw=%b alu=01", z, pw[2:0], ac[5:4],
                 {z[0], 2'b01});
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] st; logic [7:0] rw, mw, mr, pw, ill; logic [15:0] ac; int len; logic clash;
    opcode = 7'b1111111;
    capture(st, rw, mw, mr, pw, ill, ac, len, clash);
    checks++;
    if (st !== 32'hFFFFFF10 || len !== 2 || ill !== 8'b00000010) begin
      failures++;
      $display("FAIL illegal_seq got=%h len=%0d ill=%b exp=FFFFFF10 len=2 ill=00000010",
               st, len, ill);
    end
    checks++;
    if (rw !== 8'h00 || mw !== 8'h00 || state !== 4'd0) begin
      failures++;
      $display("FAIL illegal_nop rw=%b mw=%b next_state=%0d exp 0/0/0", rw, mw, state);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    opcode = 7'b0000011;
    while (state !== 4'd3 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (state !== 4'd3) begin
      failures++;
      $display("FAIL reach_memread got=%0d exp=3", state);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== 20'h0) begin
      failures++;
      $display("FAIL reset_mid_outs got=%h exp=%h", outs, 20'h0);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== FETCH_OUTS) begin
      failures++;
      $display("FAIL reset_mid_fetch got=%h exp=%h", outs, FETCH_OUTS);
    end
    step();
    checks++;
    if (state !== 4'd1) begin
      failures++;
      $display("FAIL reset_mid_decode got=%0d exp=1", state);
    end
    step();
    step();
    step();
    step();
  endtask

`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
  task automatic test_mem_wait();
    logic ok = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (state !== 4'd0 || ir_write !== 1'b0 || pc_write !== 1'b0 || mem_read !== 1'b1) ok = 1'b0;
      step();
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL mem_wait_hold got=0 exp=1");
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ir_write !== 1'b1 || pc_write !== 1'b1) begin
      failures++;
      $display("FAIL mem_wait_release ir=%b pc=%b exp 1/1", ir_write, pc_write);
    end
    step();
    checks++;
    if (state !== 4'd1) begin
      failures++;
      $display("FAIL mem_wait_decode got=%0d exp=1", state);
    end
    step();
    step();
    step();
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_addi();
    test_beq();
    test_illegal();
    test_reset_mid();
`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; encodings below are fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  7  instr[6:0] from instruction register; valid from DECODE onward.
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7_5  input  1  instr[30].
REQ-007 zero  input  1  ALU zero flag, same cycle.
REQ-008 pc_write  output  1  PC register load enable.
REQ-009 ir_write  output  1  instruction register (and OldPC) load enable.
REQ-010 adr_src  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-011 mem_read, mem_write  output  1 each  memory strobes.
REQ-012 reg_write  output  1  register file write enable.
REQ-013 alu_src_a  output  2  00=PC, 01=OldPC, 10=rs1 (reg A).
REQ-014 alu_src_b  output  2  00=rs2 (reg B), 01=immediate, 10=constant 4.
REQ-015 result_src  output  2  00=ALUOut, 01=memory data, 10=ALU result (direct).
REQ-016 alu_control  output  2  00=ADD, 01=SUB, 10=AND, 11=OR.
REQ-017 instr_done  output  1  one-cycle pulse on final cycle of each instruction.
REQ-018 illegal_instr  output  1  one-cycle pulse in DECODE for an unsupported opcode.
REQ-019 state  output  4  current state code, for debug.

Function
REQ-020 State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9; codes 10-15 SHALL go to FETCH on the next edge.
REQ-021 Outputs are a decode of state (plus zero); any output not listed for a state is 0.
REQ-022 FETCH: adr_src=0, mem_read=1, ir_write=1, alu_src_a=00, alu_src_b=10, ADD, result_src=10, pc_write=1; next state DECODE.
REQ-023 DECODE: alu_src_a=01, alu_src_b=01, ADD (branch target into ALUOut); next state by opcode:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BEQ
- otherwise -> FETCH with illegal_instr=1 and instr_done=1 (instruction executes as a NOP).
REQ-024 MEMADR: alu_src_a=10, alu_src_b=01, ADD; next state MEMREAD if opcode=0000011, else MEMWRITE.
REQ-025 MEMREAD: adr_src=1, mem_read=1, result_src=00; next state MEMWB.
REQ-026 MEMWB: result_src=01, reg_write=1, instr_done=1; next state FETCH.
REQ-027 MEMWRITE: adr_src=1, mem_write=1, result_src=00, instr_done=1; next state FETCH.
REQ-028 EXECR: alu_src_a=10, alu_src_b=00; alu_control from {funct7_5,funct3}:
- 0000 -> ADD
- 1000 -> SUB
- 0111 -> AND
- 0110 -> OR
- any other combination -> ADD
Next state ALUWB.
REQ-029 EXECI: alu_src_a=10, alu_src_b=01, ADD; next state ALUWB.
REQ-030 ALUWB: result_src=00, reg_write=1, instr_done=1; next state FETCH.
REQ-031 BEQ: alu_src_a=10, alu_src_b=00, SUB, result_src=00, pc_write=zero, instr_done=1; next state FETCH.
REQ-032 Latency in cycles, FETCH through done: lw 5, sw 4, R-type 4, addi 4, beq 3, illegal 2.
REQ-033 mem_read and mem_write SHALL never be high in the same cycle; reg_write and mem_write likewise.

Reset
REQ-034 While reset=1, every output SHALL be 0 (state output included), independent of state.
REQ-035 The first rising edge with reset=1 SHALL load state FETCH; the first cycle after release executes FETCH.
REQ-036 Reset asserted mid-instruction SHALL abandon that instruction; no write enable is asserted in the reset cycle.

Configuration
REQ-037 Macro MULTICYCLE_CONTROL_MEM_WAIT_EN.
- Defined: adds input mem_ready (1 bit). FETCH, MEMREAD and MEMWRITE hold state and all outputs while mem_ready=0. ir_write and pc_write in FETCH, and instr_done in MEMWRITE, assert only in the cycle where mem_ready=1. The state advances on that cycle.
- Undefined: no mem_ready port; every state lasts exactly one cycle.

Verification
REQ-038 Reset for 2 cycles, release, lw x1,0(x2) (opcode 0000011) -> state sequence 0,1,2,3,4; reg_write=1 only in state 4; instr_done at cycle 5.
REQ-039 sw (0100011) -> states 0,1,2,5; mem_write=1 only in state 5; 4 cycles.
REQ-040 R-type with {funct7_5,funct3}=1000 then 0110 -> alu_control=01 then 11 in EXECR; ALUWB reg_write=1.
REQ-041 beq with zero=1 -> pc_write=1 in state 9; repeat with zero=0 -> pc_write=0; each takes 3 cycles.
REQ-042 opcode 1111111 -> illegal_instr=1 in DECODE, then FETCH; no reg_write or mem_write. Reset asserted in MEMREAD -> all outputs 0, then FETCH.
REQ-043 With MEM_WAIT_EN defined, mem_ready low for 3 cycles in FETCH -> state 0 held, ir_write=0 and pc_write=0 until mem_ready=1, then DECODE.
